// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Build option: PLL_SEQ_STATS_EN enables the lock-loss / retry statistics counters.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } seq_state_t;

  localparam int STAT_W = 8;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    if (&v) return v;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL locked flag
// into the reference clock domain; clears to 0 on reset.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer on the free-running refclk.
// Build option: PLL_SEQ_STATS_EN adds lock_loss_cnt / retry_cnt counters.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 20
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic              timeout_err,
  output logic [STAT_W-1:0] lock_loss_cnt,
  output logic [STAT_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_END =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_END =
    CNT_W'(LOCK_STABLE_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             to_evt;
  logic             locked_s;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Lock seen on the timeout cycle takes priority over the retry.
  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    to_evt  = 1'b0;
    unique case (1'b1)
      (state == PLL_RST): begin
        if (cnt == RST_END) begin
          nxt     = WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      (state == WAIT_LOCK): begin
        if (locked_s) begin
          nxt     = STABLE;
          cnt_clr = 1'b1;
        end else if (cnt == TO_END) begin
          nxt     = PLL_RST;
          cnt_clr = 1'b1;
          to_evt  = 1'b1;
        end
      end
      (state == STABLE): begin
        if (!locked_s) begin
          nxt     = WAIT_LOCK;
          cnt_clr = 1'b1;
        end else if (cnt == ST_END) begin
          nxt     = RUN;
          cnt_clr = 1'b1;
        end
      end
      (state == RUN): begin
        if (!locked_s) begin
          nxt     = PLL_RST;
          cnt_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decode the next state so they line up with the state flop.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= nxt;
      pll_rst <= (nxt == PLL_RST);
      sys_rst <= (nxt != RUN);
      ready   <= (nxt == RUN);
      if (cnt_clr || nxt == RUN) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (to_evt) timeout_err <= 1'b1;
    end
  end

`ifdef PLL_SEQ_STATS_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      if (loss_evt) lock_loss_cnt <= sat_inc(lock_loss_cnt);
      if (to_evt)   retry_cnt     <= sat_inc(retry_cnt);
    end
  end
`else
  assign lock_loss_cnt = '0;
  assign retry_cnt     = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized self-checking bench for pll_lock_sequencer with a
// countdown-based behavioural reference model.
module tb_pll_lock_sequencer;

  localparam int PR = 4;
  localparam int TO = 50;
  localparam int ST = 10;
  localparam int SS = 2;

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_QUAL  = 2;
  localparam int P_RUN   = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .SYNC_STAGES         (SS),
    .CNT_W               (20)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .timeout_err   (timeout_err),
    .lock_loss_cnt (lock_loss_cnt),
    .retry_cnt     (retry_cnt)
  );

  always #5 refclk = ~refclk;

  int pass_cnt = 0;
  int total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  function automatic int stat(input int v);
`ifdef PLL_SEQ_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Model: phase plus a cycles-remaining countdown.
  int m_phase, m_left, m_terr, m_retry, m_loss;
  bit m_valid = 0;
  bit sh [SS];
  bit ls;

  always @(posedge refclk) begin
    ls = sh[SS-1];
    if (rst) begin
      for (int i = 0; i < SS; i++) sh[i] = 0;
      m_phase = P_PULSE; m_left = PR;
      m_terr = 0; m_retry = 0; m_loss = 0;
      m_valid = 1;
    end else begin
      for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = pll_locked;
      case (m_phase)
        P_PULSE:
          if (m_left == 1) begin m_phase = P_WAIT; m_left = TO; end
          else m_left--;
        P_WAIT:
          if (ls) begin m_phase = P_QUAL; m_left = ST; end
          else if (m_left == 1) begin
            m_phase = P_PULSE; m_left = PR; m_terr = 1;
            if (m_retry < 255) m_retry++;
          end else m_left--;
        P_QUAL:
          if (!ls) begin m_phase = P_WAIT; m_left = TO; end
          else if (m_left == 1) m_phase = P_RUN;
          else m_left--;
        default:
          if (!ls) begin
            m_phase = P_PULSE; m_left = PR;
            if (m_loss < 255) m_loss++;
          end
      endcase
    end
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      check("pll_rst", int'(pll_rst), int'(m_phase == P_PULSE));
      check("sys_rst", int'(sys_rst), int'(m_phase != P_RUN));
      check("ready", int'(ready), int'(m_phase == P_RUN));
      check("timeout_err", int'(timeout_err), m_terr);
      check("retry_cnt", int'(retry_cnt), stat(m_retry));
      check("lock_loss_cnt", int'(lock_loss_cnt), stat(m_loss));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #2;
    end
  endtask

  task automatic fresh_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  // Counts ticks until sig matches val; expiry counts as a failure.
  task automatic wait_val(input string name, input int which,
                          input bit val, input int lim,
                          output int n);
    bit cur;
    n = 0;
    forever begin
      case (which)
        0: cur = pll_rst;
        1: cur = sys_rst;
        default: cur = ready;
      endcase
      if (cur == val) break;
      if (n >= lim) begin
        check({name, "_timeout"}, n, -1);
        break;
      end
      tick(1);
      n++;
    end
  endtask

  int n;
  bit saw_pulse;

  initial begin
    fresh_reset();
    check("reset_pll_rst", int'(pll_rst), 1);
    check("reset_sys_rst", int'(sys_rst), 1);
    wait_val("pulse_end", 0, 1'b0, 200, n);
    check("pll_rst_width", n, 4);
    tick(15);
    pll_locked = 1'b1;
    wait_val("lock_latency", 1, 1'b0, 200, n);
    check("lock_latency", n, 13);
    check("ready_clean", int'(ready), 1);
    check("terr_clean", int'(timeout_err), 0);

    fresh_reset();
    tick(164);
    check("terr_after_to", int'(timeout_err), 1);
    check("retry_3", int'(retry_cnt), stat(3));

    fresh_reset();
    wait_val("g_pulse", 0, 1'b0, 200, n);
    tick(5);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    saw_pulse = 0;
    n = 0;
    while (sys_rst && n < 200) begin
      tick(1);
      n++;
      if (pll_rst) saw_pulse = 1;
    end
    check("glitch_latency", n, 13);
    check("glitch_no_pulse", int'(saw_pulse), 0);

    pll_locked = 1'b0;
    wait_val("loss", 1, 1'b1, 50, n);
    wait_val("loss_pulse", 0, 1'b0, 50, n);
    check("loss_pulse_width", n, 4);
    check("loss_cnt_1", int'(lock_loss_cnt), stat(1));

    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_val("sat_up", 2, 1'b1, 200, n);
      pll_locked = 1'b0;
      wait_val("sat_dn", 2, 1'b0, 50, n);
    end
    check("loss_sat", int'(lock_loss_cnt), stat(255));

    fresh_reset();
    wait_val("edge_pulse", 0, 1'b0, 200, n);
    tick(47);
    pll_locked = 1'b1;
    tick(15);
    check("edge_terr", int'(timeout_err), 0);
    check("edge_retry", int'(retry_cnt), 0);
    check("edge_ready", int'(ready), 1);

    fresh_reset();
    tick(60);
    pll_locked = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("mid_pll_rst", int'(pll_rst), 1);
    check("mid_sys_rst", int'(sys_rst), 1);
    check("mid_terr", int'(timeout_err), 0);
    check("mid_retry", int'(retry_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 150; i++) begin
      pll_locked = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      tick(1);
      rst = 1'b0;
      tick($urandom_range(1, 70));
    end

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
